serial_chunk_adder: RTL and testbench
=====================================

Name: serial_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the one-bit full adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, with one registered carry chained between chunks.
- Trades latency for a narrow adder. Used where a wide single-cycle ripple adder is too slow or too large.
- Start/ready/done handshake. Result is held stable until the next result completes.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle. Must satisfy 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam) = WIDTH/CHUNK: number of chunk steps per operation.

Ports:
- clk    input   1      clock; all state updates on the rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only when ready=1
- A      input   WIDTH  operand A; sampled with start
- B      input   WIDTH  operand B; sampled with start
- Cin    input   1      carry-in; sampled with start
- ready  output  1      1 = idle, a start will be accepted this cycle
- done   output  1      one-cycle pulse; sum/cout updated on this cycle
- sum    output  WIDTH  registered result (A+B+Cin) mod 2^WIDTH
- cout   output  1      registered carry-out of the MSB

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE, ready=1, done=0, sum=0, cout=0.
  - Internal carry=0, chunk counter=0.
- States: IDLE, RUN.
- IDLE:
  - ready=1.
  - If start=1 at an edge: latch A, B into operand registers, carry<=Cin, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - ready=0.
  - Each edge: add chunk cnt of A_reg and B_reg plus the carry register, a (CHUNK+1)-bit result.
  - The low CHUNK bits go into chunk cnt of the internal accumulator; bit CHUNK goes to the carry register; cnt++.
  - Chunk 0 is the LSB chunk.
- Completion:
  - On the edge that processes chunk NCHUNK-1: go to IDLE, done<=1, sum<=final accumulator, cout<=final carry.
  - done falls after exactly one cycle.
- Latency:
  - start sampled at edge 0; done=1 in the cycle following edge NCHUNK.
  - That is NCHUNK cycles start-to-done.
  - NCHUNK=1 gives single-step behaviour.
- sum/cout:
  - Change only on a completion edge or on reset.
  - Partial results are never visible; the previous result is held throughout RUN.
- start while ready=0: ignored. No queueing, no effect on the operation in flight.
- Input stability: A, B, Cin may change freely after the accept edge.
- Back-to-back:
  - ready=1 in the same cycle as done=1, so a start there is accepted.
  - Peak throughput is one operation per NCHUNK cycles.
- Reset mid-RUN: operation aborted, no done pulse, outputs return to reset values.
- Carry wrap-around: a carry generated in chunk k must propagate into chunk k+1 on the next edge. Example: 0xFFFF+0+1 ripples through all chunks.
- Counter: ceil(log2(NCHUNK)) bits, minimum 1. It never exceeds NCHUNK-1.

Optional Feature:
- Macro SERIAL_CHUNK_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: B_reg is latched as ~B and carry as ~Cin, computing A-B-Cin (Cin acts as borrow-in).
  - cout=1 means no borrow.
  - sub=0: identical to the base behaviour.
- When undefined: no sub port; add-only behaviour.
- Timing and handshake are identical in both builds.

Test Plan:
- All scenarios use WIDTH=16, CHUNK=4 unless stated.
1. Assert rst for 2 cycles -> ready=1, done=0, sum=0x0000, cout=0. Release rst -> outputs unchanged, no done.
2. start, A=0x1234, B=0x4321, Cin=0 -> ready=0 for 4 cycles; done=1 exactly 4 cycles after accept; sum=0x5555, cout=0; done low next cycle; sum held.
3. A=0xFFFF, B=0x0000, Cin=1 -> sum=0x0000, cout=1; sum stays at the previous value (0x5555) throughout RUN.
4. Hold start=1 during RUN with A=0xAAAA -> ignored. Raise start in the done cycle with A=0x8000, B=0x8000, Cin=0 -> accepted, next done gives sum=0x0000, cout=1.
5. Accept A=0x0F0F, B=0x0101; assert rst 2 cycles later -> no done pulse ever; ready=1, sum=0 the cycle after rst.
6. CHUNK=16: A=0x00FF, B=0x0001, Cin=0 -> done 1 cycle after accept, sum=0x0100. With SUB_EN defined, base config: sub=1, A=0x0005, B=0x0007, Cin=0 -> sum=0xFFFE, cout=0.

Source files
------------

// File: rtl/serial_chunk_adder_if.sv
// Handshake and data bundle for serial_chunk_adder.
// The optional subtract control appears only when SERIAL_CHUNK_ADDER_SUB_EN is defined.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: issues operations and observes the result.
    modport master (
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        output sub,
`endif
        output start, A, B, Cin,
        input  ready, done, sum, cout
    );

    // Adder side: accepts operations and publishes the result.
    modport slave (
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        input  sub,
`endif
        input  start, A, B, Cin,
        output ready, done, sum, cout
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per
// clock, with a registered carry linking successive chunks (LSB chunk first).
// Optional subtract mode is enabled by defining SERIAL_CHUNK_ADDER_SUB_EN.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    // Reject configurations the chunk slicing cannot represent.
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     chunk_sum;
    int                 base;
    logic               sub_sel;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Narrow adder for the chunk currently selected by the counter.
    always_comb begin
        base      = int'(cnt_q) * CHUNK;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state logic: accept in IDLE, step one chunk per cycle in RUN.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + ~borrow, so invert B and Cin on capture.
                    a_d     = bus.A;
                    b_d     = sub_sel ? ~bus.B : bus.B;
                    carry_d = bus.Cin ^ sub_sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    sum_d   = acc_d;
                    cout_d  = chunk_sum[CHUNK];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

    // The chunk counter must never address past the last chunk.
    cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST);

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: a 16/4 instance and a 16/16 instance
// share clock and reset. Subtract checks are built when SERIAL_CHUNK_ADDER_SUB_EN is defined.
module tb_serial_chunk_adder;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_chunk_adder_if #(.WIDTH(WIDTH)) bus4 ();
    serial_chunk_adder_if #(.WIDTH(WIDTH)) bus16 ();

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation on the 4-bit-chunk instance.
    task automatic drive4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus4.start = 1'b1;
        bus4.A     = a;
        bus4.B     = b;
        bus4.Cin   = cin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus4.ready !== 1'b1 || bus4.done !== 1'b0 || bus4.sum !== 16'h0000 || bus4.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b done=%b sum=%h cout=%b, want 1 0 0000 0",
                     bus4.ready, bus4.done, bus4.sum, bus4.cout);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (bus4.ready !== 1'b1 || bus4.done !== 1'b0 || bus4.sum !== 16'h0000 || bus4.cout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: ready=%b done=%b sum=%h cout=%b, want 1 0 0000 0",
                         i, bus4.ready, bus4.done, bus4.sum, bus4.cout);
            end
        end
    endtask

    // Generic operation on the 4-bit instance: checks busy/held-result during RUN,
    // done timing, result, and done falling after one cycle.
    task automatic run_op4(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] prev_sum,
                           input logic [15:0] exp_sum, input logic exp_cout);
        drive4(a, b, cin);
        step();
        bus4.start = 1'b0;
        bus4.A     = 16'hDEAD;
        bus4.B     = 16'hBEEF;
        bus4.Cin   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus4.ready !== 1'b0 || bus4.done !== 1'b0 || bus4.sum !== prev_sum) begin
                n_fail++;
                $display("FAIL %s_run[%0d]: ready=%b done=%b sum=%h, want 0 0 %h",
                         name, i, bus4.ready, bus4.done, bus4.sum, prev_sum);
            end
            step();
        end
        n_tests++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1 || bus4.sum !== exp_sum || bus4.cout !== exp_cout) begin
            n_fail++;
            $display("FAIL %s_done: done=%b ready=%b sum=%h cout=%b, want 1 1 %h %b",
                     name, bus4.done, bus4.ready, bus4.sum, bus4.cout, exp_sum, exp_cout);
        end
        step();
        n_tests++;
        if (bus4.done !== 1'b0 || bus4.sum !== exp_sum || bus4.cout !== exp_cout) begin
            n_fail++;
            $display("FAIL %s_hold: done=%b sum=%h cout=%b, want 0 %h %b",
                     name, bus4.done, bus4.sum, bus4.cout, exp_sum, exp_cout);
        end
    endtask

    task automatic test_add();
        run_op4("add", 16'h1234, 16'h4321, 1'b0, 16'h0000, 16'h5555, 1'b0);
    endtask

    task automatic test_carry_ripple();
        run_op4("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h5555, 16'h0000, 1'b1);
        run_op4("mixed", 16'h0F0F, 16'h00F1, 1'b0, 16'h0000, 16'h1000, 1'b0);
    endtask

    task automatic test_back_to_back();
        // 0x1111+0x1111 = 0x2222; start stays high with 0xAAAA operands during RUN.
        drive4(16'h1111, 16'h1111, 1'b0);
        step();
        drive4(16'hAAAA, 16'hAAAA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus4.ready !== 1'b0 || bus4.done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_busy[%0d]: ready=%b done=%b, want 0 0", i, bus4.ready, bus4.done);
            end
            step();
        end
        n_tests++;
        if (bus4.done !== 1'b1 || bus4.ready !== 1'b1 || bus4.sum !== 16'h2222 || bus4.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b ready=%b sum=%h cout=%b, want 1 1 2222 0",
                     bus4.done, bus4.ready, bus4.sum, bus4.cout);
        end
        // Start in the done cycle must be accepted.
        drive4(16'h8000, 16'h8000, 1'b0);
        step();
        bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus4.ready !== 1'b0 || bus4.done !== 1'b0 || bus4.sum !== 16'h2222) begin
                n_fail++;
                $display("FAIL b2b_second_run[%0d]: ready=%b done=%b sum=%h, want 0 0 2222",
                         i, bus4.ready, bus4.done, bus4.sum);
            end
            step();
        end
        n_tests++;
        if (bus4.done !== 1'b1 || bus4.sum !== 16'h0000 || bus4.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b sum=%h cout=%b, want 1 0000 1",
                     bus4.done, bus4.sum, bus4.cout);
        end
        step();
    endtask

    task automatic test_reset_abort();
        run_op4("pre_abort", 16'h0001, 16'h0001, 1'b0, 16'h0000, 16'h0002, 1'b0);
        drive4(16'h0F0F, 16'h0101, 1'b0);
        step();
        bus4.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if (bus4.ready !== 1'b1 || bus4.done !== 1'b0 || bus4.sum !== 16'h0000 || bus4.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: ready=%b done=%b sum=%h cout=%b, want 1 0 0000 0",
                     bus4.ready, bus4.done, bus4.sum, bus4.cout);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (bus4.done !== 1'b0 || bus4.ready !== 1'b1 || bus4.sum !== 16'h0000) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: done=%b ready=%b sum=%h, want 0 1 0000",
                         i, bus4.done, bus4.ready, bus4.sum);
            end
        end
    endtask

    task automatic test_single_chunk();
        bus16.start = 1'b1;
        bus16.A     = 16'h00FF;
        bus16.B     = 16'h0001;
        bus16.Cin   = 1'b0;
        n_tests++;
        if (bus16.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: ready=%b, want 1", bus16.ready);
        end
        step();
        bus16.start = 1'b0;
        step();
        n_tests++;
        if (bus16.done !== 1'b1 || bus16.sum !== 16'h0100 || bus16.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b sum=%h cout=%b, want 1 0100 0",
                     bus16.done, bus16.sum, bus16.cout);
        end
        step();
        n_tests++;
        if (bus16.done !== 1'b0 || bus16.sum !== 16'h0100) begin
            n_fail++;
            $display("FAIL single_hold: done=%b sum=%h, want 0 0100", bus16.done, bus16.sum);
        end
    endtask

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    task automatic test_sub();
        bus4.sub = 1'b1;
        // 5 - 7 = -2 -> 0xFFFE with a borrow (cout=0).
        run_op4("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'h0000, 16'hFFFE, 1'b0);
        // 7 - 5 - 1 = 1 with no borrow (cout=1).
        run_op4("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'hFFFE, 16'h0001, 1'b1);
        bus4.sub = 1'b0;
        run_op4("sub_off", 16'h0007, 16'h0005, 1'b1, 16'h0001, 16'h000D, 1'b0);
    endtask
`endif

    initial begin
        bus4.start  = 1'b0;
        bus4.A      = '0;
        bus4.B      = '0;
        bus4.Cin    = 1'b0;
        bus16.start = 1'b0;
        bus16.A     = '0;
        bus16.B     = '0;
        bus16.Cin   = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        bus4.sub    = 1'b0;
        bus16.sub   = 1'b0;
`endif
        #2;
        test_reset();
        test_add();
        test_carry_ripple();
        test_back_to_back();
        test_reset_abort();
        test_single_chunk();
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units, want completion");
        $fatal(1);
    end
endmodule
